// File: rtl/branch_pred_unit_pkg.sv
// branch_pkg: shared types and helpers for the branch prediction unit.
//   bht_entry_t : one table entry {valid, ctr, target}. The ctr field is sized for
//                 the widest supported counter (CTR_W_MAX); only the low CTR_W bits
//                 are meaningful for a given instance.
//   ctr_init    : weakly-not-taken reset value for a w-bit counter.
//   ctr_next    : saturating up/down step for a w-bit counter.
//   CTR_INIT    : reset value for the default 2-bit counter.
package branch_pkg;

  localparam int unsigned CTR_W_MAX = 8;
  localparam int unsigned CTR_W_DEF = 2;

  typedef struct packed {
    logic                 valid;
    logic [CTR_W_MAX-1:0] ctr;
    logic [31:0]          target;
  } bht_entry_t;

  function automatic logic [CTR_W_MAX-1:0] ctr_max(input int unsigned w);
    return CTR_W_MAX'((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_init(input int unsigned w);
    return CTR_W_MAX'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  localparam logic [CTR_W_MAX-1:0] CTR_INIT = ctr_init(CTR_W_DEF);

  function automatic logic [CTR_W_MAX-1:0] ctr_next(input logic [CTR_W_MAX-1:0] ctr,
                                                   input logic                 taken,
                                                   input int unsigned          w);
    logic [CTR_W_MAX-1:0] lim;
    lim = ctr_max(w);
    if (taken) begin
      return (ctr >= lim) ? lim : ctr + 1'b1;
    end
    return (ctr == '0) ? '0 : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/branch_pred_unit_bht_table.sv
// bht_table: direct-mapped branch history table storage.
//   clk, reset         : clock, asynchronous active-low reset (clears every entry)
//   rd_idx_i/rd_entry_o: asynchronous read port (IF lookup, pre-update value)
//   wr_en_i, wr_idx_i,
//   wr_taken_i,
//   wr_target_i        : synchronous read-modify-write update port (EX resolve)
module bht_table
  import branch_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_entry_t       rd_entry_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i,
  input  logic [31:0]      wr_target_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [CTR_W-1:0] ctr_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= CTR_W'(ctr_init(CTR_W));
        target_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      ctr_q[wr_idx_i]   <= CTR_W'(ctr_next(CTR_W_MAX'(ctr_q[wr_idx_i]), wr_taken_i, CTR_W));
      if (wr_taken_i) begin
        target_q[wr_idx_i] <= wr_target_i;
      end
    end
  end

  always_comb begin
    rd_entry_o        = '0;
    rd_entry_o.valid  = valid_q[rd_idx_i];
    rd_entry_o.ctr    = CTR_W_MAX'(ctr_q[rd_idx_i]);
    rd_entry_o.target = target_q[rd_idx_i];
  end

endmodule

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: EX-stage branch/JAL/JALR/halt resolution plus a dynamic
// predictor (direct-mapped BHT of saturating counters with target field).
//   clk, reset                      : clock, asynchronous active-low reset
//   if_pc -> if_pred_taken/_target  : zero-latency IF lookup
//   ex_* inputs                     : instruction in EX and its piped prediction
//   ex_pc_four                      : link value (ex_pc when halting)
//   ex_br_pc, ex_pc_sel, ex_flush   : redirect on mispredict or halt
// Optional build macro BRANCH_STATS_EN adds 32-bit outputs stat_branches
// (table update events) and stat_mispred (mispredicted cycles).
module branch_pred_unit
  import branch_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CTR_W     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [31:0]     if_pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic            ex_branch,
  input  logic            ex_jalr,
  input  logic            ex_halt,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     ex_pc_four,
  output logic [31:0]     ex_br_pc,
  output logic            ex_pc_sel,
  output logic            ex_flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  bht_entry_t  rd_entry;
  logic [31:0] ex_pc32;
  logic [31:0] act_tgt;
  logic        act_taken;
  logic        mispred;
  logic        halt_v;
  logic        upd_en;
  logic        unused_bits;

  bht_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (if_pc[IDX_W+1:2]),
    .rd_entry_o  (rd_entry),
    .wr_en_i     (upd_en),
    .wr_idx_i    (ex_pc[IDX_W+1:2]),
    .wr_taken_i  (act_taken),
    .wr_target_i (act_tgt)
  );

  // Untagged lookup: fetch PC bits outside the index and the unused counter
  // bits of the wide entry type are deliberately ignored.
  assign unused_bits = ^{if_pc, rd_entry.ctr};

  assign if_pred_taken  = rd_entry.valid & rd_entry.ctr[CTR_W-1];
  assign if_pred_target = if_pred_taken ? rd_entry.target : '0;

  assign ex_pc32   = 32'(ex_pc);
  assign act_taken = ex_valid & ((ex_branch & ex_alu_result[0]) | ex_jalr);
  assign act_tgt   = ex_jalr ? ex_alu_result : ex_pc32 + ex_imm;
  assign mispred   = ex_valid & ~ex_halt &
                     ((act_taken != ex_pred_taken) | (act_taken & (act_tgt != ex_pred_target)));
  assign halt_v    = ex_valid & ex_halt;
  assign upd_en    = ex_valid & ~ex_halt & (ex_branch | ex_jalr);

  assign ex_pc_four = ex_halt ? ex_pc32 : ex_pc32 + 32'd4;

  always_comb begin
    ex_pc_sel = 1'b0;
    ex_flush  = 1'b0;
    ex_br_pc  = '0;
    if (halt_v) begin
      ex_pc_sel = 1'b1;
      ex_flush  = 1'b1;
      ex_br_pc  = ex_pc32;
    end else if (mispred) begin
      ex_pc_sel = 1'b1;
      ex_flush  = 1'b1;
      ex_br_pc  = act_taken ? act_tgt : ex_pc32 + 32'd4;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispred_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (upd_en) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if (mispred) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`else
  // No statistics hardware in this build.
`endif

endmodule
